// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte sources. One byte is in flight at a time: grant, write
// strobe, wait for tx_busy to rise, wait for tx_busy to fall.
// Optional macro UART_TX_ARB_TIMEOUT_EN: bounds the wait for tx_busy to rise
// to TIMEOUT cycles and raises a sticky err_timeout when it expires.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_en,
  output logic                 tx_wr,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 arb_busy,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_START, WAIT_DONE} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT >= 1");
  end

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  grant_id_q, grant_id_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;

  // Requests/data padded to 8 slots so a 3-bit pointer can index them.
  logic [7:0]      req_pad;
  logic [7:0][7:0] data_pad;
  logic            found;
  logic [2:0]      winner;
  logic [2:0]      rr_nxt;

  for (genvar g = 0; g < 8; g++) begin : g_pad
    if (g < NUM_REQ) begin : g_used
      assign req_pad[g]  = req_valid[g];
      assign data_pad[g] = req_data[8*g +: 8];
      assign req_ack[g]  = (state_q == WRITE) && (grant_id_q == 3'(g));
    end else begin : g_unused
      assign req_pad[g]  = 1'b0;
      assign data_pad[g] = 8'h00;
    end
  end

  // Round-robin search: first valid request at or after rr_ptr, wrapping.
  always_comb begin
    int s;
    int n;
    found  = 1'b0;
    winner = '0;
    s      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      if (!found && req_pad[3'(s)]) begin
        found  = 1'b1;
        winner = 3'(s);
      end
    end
    n = int'(winner) + 1;
    if (n >= NUM_REQ) n = 0;
    rr_nxt = 3'(n);
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  // Next-state and grant capture; the byte is latched at grant so later
  // changes on req_data/req_valid cannot disturb the transfer.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    tx_data_d  = tx_data_q;
    tx_en_d    = enable;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d      = '0;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && !tx_busy && found) begin
          tx_data_d  = data_pad[winner];
          grant_id_d = winner;
          rr_ptr_d   = rr_nxt;
          state_d    = WRITE;
        end
      end
      WRITE: state_d = WAIT_START;
      WAIT_START: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        if (tx_busy) state_d = WAIT_DONE;
`endif
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any byte in flight without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      tx_data_q  <= '0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      tx_data_q  <= tx_data_d;
      tx_en_q    <= tx_en_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // Start-of-transmission watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  assign tx_wr    = (state_q == WRITE);
  assign tx_data  = tx_data_q;
  assign tx_en    = tx_en_q;
  assign grant_id = grant_id_q;
  assign arb_busy = (state_q != IDLE);

endmodule
